// File: rtl/ahb_bus_arbiter.sv
// AHB-lite arbiter: registered one-hot grant, combinational address/control mux, HREADY-tracked HWDATA mux.
// Request to grant takes 1 cycle when re-arbitrable; HREADY=0, SEQ/BUSY beats or HLOCK freeze the grant.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_bus_arbiter #(
  parameter int NUM_MST   = 2,
  parameter int MST_IDX_W = 2
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NUM_MST-1:0]                 m_hbusreq,
  input  logic [NUM_MST-1:0]                 m_hlock,
  input  logic [2*NUM_MST-1:0]               m_htrans,
  input  logic [`AHB_ADDR_WIDTH*NUM_MST-1:0] m_haddr,
  input  logic [NUM_MST-1:0]                 m_hwrite,
  input  logic [3*NUM_MST-1:0]               m_hsize,
  input  logic [3*NUM_MST-1:0]               m_hburst,
  input  logic [4*NUM_MST-1:0]               m_hprot,
  input  logic [`AHB_DATA_WIDTH*NUM_MST-1:0] m_hwdata,
  output logic [NUM_MST-1:0]                 m_hgrant,
  input  logic                               HREADY,
  output logic [1:0]                         HTRANS,
  output logic [`AHB_ADDR_WIDTH-1:0]         HADDR,
  output logic                               HWRITE,
  output logic [2:0]                         HSIZE,
  output logic [2:0]                         HBURST,
  output logic [3:0]                         HPROT,
  output logic [`AHB_DATA_WIDTH-1:0]         HWDATA,
  output logic [MST_IDX_W-1:0]               HMASTER,
  output logic                               HMASTLOCK
);

  localparam int AW = `AHB_ADDR_WIDTH;
  localparam int DW = `AHB_DATA_WIDTH;
  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  generate
    if (NUM_MST < 2 || NUM_MST > 4 || (2**MST_IDX_W) < NUM_MST) begin : g_param_err
      $error("ahb_bus_arbiter: NUM_MST must be 2..4 and fit in MST_IDX_W bits");
    end
  endgenerate

  logic [NUM_MST-1:0]   grant_q, grant_d;
  logic [MST_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MST_IDX_W-1:0] data_owner_q;
  logic [MST_IDX_W-1:0] owner;
  logic                 owner_req;
  logic                 owner_lock;
  logic [1:0]           owner_trans;
  logic                 rearb;
  logic [NUM_MST-1:0]   cand;
  logic                 found;
  int                   pick;

  // Address-phase mux, one-hot select on the registered grant.
  always_comb begin
    owner       = '0;
    owner_req   = 1'b0;
    owner_lock  = 1'b0;
    owner_trans = TR_IDLE;
    HADDR       = '0;
    HWRITE      = 1'b0;
    HSIZE       = '0;
    HBURST      = '0;
    HPROT       = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant_q[i]) begin
        owner       = MST_IDX_W'(i);
        owner_req   = m_hbusreq[i];
        owner_lock  = m_hlock[i];
        owner_trans = m_htrans[2*i +: 2];
        HADDR       = m_haddr[i*AW +: AW];
        HWRITE      = m_hwrite[i];
        HSIZE       = m_hsize[3*i +: 3];
        HBURST      = m_hburst[3*i +: 3];
        HPROT       = m_hprot[4*i +: 4];
      end
    end
    HTRANS    = owner_req ? owner_trans : TR_IDLE;
    HMASTER   = owner;
    HMASTLOCK = owner_lock;
  end

  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (data_owner_q == MST_IDX_W'(i)) HWDATA = m_hwdata[i*DW +: DW];
    end
  end

  // Raw owner HTRANS is used so a burst is never split, even if busreq drops early.
  assign rearb = HREADY && (owner_trans != TR_SEQ) && (owner_trans != TR_BUSY) && !owner_lock;

  always_comb begin
    cand     = m_hbusreq & ~grant_q;
    if (cand == '0) cand = m_hbusreq;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    pick     = 0;
    if (rearb && (|m_hbusreq)) begin
      if (cand[1] && !m_hbusreq[0]) begin
        pick  = 1;
        found = 1'b1;
      end
      for (int off = 0; off < NUM_MST; off++) begin
        for (int j = 0; j < NUM_MST; j++) begin
          if (!found && cand[j] && (j == (int'(rr_ptr_q) + off) % NUM_MST)) begin
            pick  = j;
            found = 1'b1;
          end
        end
      end
      for (int j = 0; j < NUM_MST; j++) grant_d[j] = (j == pick);
      rr_ptr_d = MST_IDX_W'((pick + 1) % NUM_MST);
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q      <= NUM_MST'(1);
      rr_ptr_q     <= '0;
      data_owner_q <= '0;
    end else begin
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (HREADY) data_owner_q <= owner;
    end
  end

  assign m_hgrant = grant_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (2 masters, 32-bit address/data).
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [31:0] D0 = 32'hC0C0_0000, D1 = 32'hD1D1_0001;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  m_hbusreq, m_hlock, m_hwrite;
  logic [3:0]  m_htrans;
  logic [63:0] m_haddr, m_hwdata;
  logic [5:0]  m_hsize, m_hburst;
  logic [7:0]  m_hprot;
  logic [1:0]  m_hgrant;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HMASTER;

  int checks = 0;
  int errors = 0;

  ahb_bus_arbiter #(.NUM_MST(2), .MST_IDX_W(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_hbusreq(m_hbusreq), .m_hlock(m_hlock), .m_htrans(m_htrans),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
    .m_hgrant(m_hgrant), .HREADY(HREADY),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1;
    m_hbusreq = '0; m_hlock = '0; m_htrans = '0; m_hwrite = 2'b10;
    m_haddr = {32'h2000_0000, 32'h0000_0100};
    m_hwdata = {D1, D0};
    m_hsize = {3'd2, 3'd2}; m_hburst = '0; m_hprot = {4'h3, 4'h1};
    step(); step();
    HRESETn = 1'b1;
    #1;
    checks++; if (m_hgrant !== 2'b01) begin errors++; $display("FAIL rst_grant got %b exp 01", m_hgrant); end
    checks++; if (HMASTER !== 2'd0) begin errors++; $display("FAIL rst_hmaster got %0d exp 0", HMASTER); end
    checks++; if (HTRANS !== IDLE) begin errors++; $display("FAIL rst_htrans got %b exp 00", HTRANS); end
    checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL rst_lock got %b exp 0", HMASTLOCK); end
    checks++; if (HWDATA !== D0) begin errors++; $display("FAIL rst_hwdata got %h exp %h", HWDATA, D0); end
    step();
    checks++; if (m_hgrant !== 2'b01) begin errors++; $display("FAIL rst_park got %b exp 01", m_hgrant); end
  endtask

  task automatic test_grant_m1();
    m_hbusreq = 2'b10; m_htrans = {NSEQ, IDLE};
    step();
    checks++; if (m_hgrant !== 2'b10) begin errors++; $display("FAIL m1_grant got %b exp 10", m_hgrant); end
    checks++; if (HMASTER !== 2'd1) begin errors++; $display("FAIL m1_hmaster got %0d exp 1", HMASTER); end
    checks++; if (HTRANS !== NSEQ) begin errors++; $display("FAIL m1_htrans got %b exp 10", HTRANS); end
    checks++; if (HADDR !== 32'h2000_0000) begin errors++; $display("FAIL m1_haddr got %h exp 20000000", HADDR); end
    checks++; if (HWRITE !== 1'b1 || HPROT !== 4'h3) begin errors++; $display("FAIL m1_ctrl got %b/%h exp 1/3", HWRITE, HPROT); end
    checks++; if (HWDATA !== D0) begin errors++; $display("FAIL m1_hwdata_early got %h exp %h", HWDATA, D0); end
    m_hbusreq = 2'b00; m_htrans = {IDLE, IDLE};
    step();
    checks++; if (HWDATA !== D1) begin errors++; $display("FAIL m1_hwdata got %h exp %h", HWDATA, D1); end
    checks++; if (m_hgrant !== 2'b10) begin errors++; $display("FAIL m1_park got %b exp 10", m_hgrant); end
    checks++; if (HTRANS !== IDLE) begin errors++; $display("FAIL m1_idle_mask got %b exp 00", HTRANS); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    m_hbusreq = 2'b11; m_htrans = {NSEQ, NSEQ};
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (m_hgrant !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, m_hgrant, exp_g[k]); end
      checks++; if (HADDR !== (exp_g[k][1] ? 32'h2000_0000 : 32'h0000_0100)) begin errors++; $display("FAIL rr_haddr[%0d] got %h", k, HADDR); end
    end
  endtask

  task automatic test_burst();
    m_hbusreq = 2'b01; m_htrans = {IDLE, NSEQ}; m_hburst = {3'b000, 3'b011};
    m_haddr[31:0] = 32'h0000_0100;
    step();
    checks++; if (m_hgrant !== 2'b01 || HTRANS !== NSEQ || HBURST !== 3'b011) begin errors++; $display("FAIL burst_start got %b/%b/%b exp 01/10/011", m_hgrant, HTRANS, HBURST); end
    m_hbusreq = 2'b11; m_htrans = {NSEQ, SEQ};
    for (int b = 1; b < 4; b++) begin
      m_haddr[31:0] = 32'h0000_0100 + 32'(4*b);
      #1;
      checks++; if (m_hgrant !== 2'b01 || HTRANS !== SEQ || HADDR !== 32'h0000_0100 + 32'(4*b)) begin errors++; $display("FAIL burst_beat[%0d] got %b/%b/%h", b, m_hgrant, HTRANS, HADDR); end
      step();
    end
    m_hbusreq = 2'b10; m_htrans = {NSEQ, IDLE};
    #1;
    checks++; if (m_hgrant !== 2'b01) begin errors++; $display("FAIL burst_hold got %b exp 01", m_hgrant); end
    step();
    checks++; if (m_hgrant !== 2'b10 || HTRANS !== NSEQ) begin errors++; $display("FAIL burst_handover got %b/%b exp 10/10", m_hgrant, HTRANS); end
  endtask

  task automatic test_hready_stall();
    m_hbusreq = 2'b11; m_htrans = {NSEQ, NSEQ}; m_hburst = '0;
    m_hwdata[63:32] = 32'hD1D1_0005;
    step();
    HREADY = 1'b0;
    #1;
    checks++; if (m_hgrant !== 2'b01 || HWDATA !== 32'hD1D1_0005) begin errors++; $display("FAIL stall_entry got %b/%h exp 01/d1d10005", m_hgrant, HWDATA); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (m_hgrant !== 2'b01) begin errors++; $display("FAIL stall_grant[%0d] got %b exp 01", c, m_hgrant); end
      checks++; if (HWDATA !== 32'hD1D1_0005) begin errors++; $display("FAIL stall_hwdata[%0d] got %h exp d1d10005", c, HWDATA); end
    end
    HREADY = 1'b1;
    step();
    checks++; if (m_hgrant !== 2'b10) begin errors++; $display("FAIL stall_release got %b exp 10", m_hgrant); end
    checks++; if (HWDATA !== D0) begin errors++; $display("FAIL stall_release_hwdata got %h exp %h", HWDATA, D0); end
  endtask

  task automatic test_lock_and_reset();
    m_hbusreq = 2'b01; m_htrans = {IDLE, NSEQ}; m_hlock = 2'b01;
    step();
    checks++; if (m_hgrant !== 2'b01 || HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_grant got %b/%b exp 01/1", m_hgrant, HMASTLOCK); end
    m_hbusreq = 2'b11; m_htrans = {NSEQ, NSEQ};
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (m_hgrant !== 2'b01 || HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_hold[%0d] got %b/%b exp 01/1", c, m_hgrant, HMASTLOCK); end
    end
    m_hlock = 2'b00;
    step();
    checks++; if (m_hgrant !== 2'b10 || HMASTLOCK !== 1'b0 || HMASTER !== 2'd1) begin errors++; $display("FAIL lock_drop got %b/%b/%0d exp 10/0/1", m_hgrant, HMASTLOCK, HMASTER); end
    step();
    HRESETn = 1'b0; HREADY = 1'b0;
    step();
    checks++; if (m_hgrant !== 2'b01 || HMASTER !== 2'd0) begin errors++; $display("FAIL midrst_grant got %b/%0d exp 01/0", m_hgrant, HMASTER); end
    checks++; if (HWDATA !== D0) begin errors++; $display("FAIL midrst_hwdata got %h exp %h", HWDATA, D0); end
    HRESETn = 1'b1; HREADY = 1'b1; m_hbusreq = 2'b00; m_htrans = '0;
    step();
    checks++; if (m_hgrant !== 2'b01 || HTRANS !== IDLE) begin errors++; $display("FAIL postrst got %b/%b exp 01/00", m_hgrant, HTRANS); end
  endtask

  initial begin
    test_reset();
    test_grant_m1();
    test_round_robin();
    test_burst();
    test_hready_stall();
    test_lock_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
